uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Serial command receiver: the inbound counterpart of the result transmit path. Deserialises 8N1 UART bytes on `rx`, assembles 3-byte command frames (header/opcode, operand A, operand B), and presents each completed command on a valid/ready interface to the ALU sequencing logic. Framing errors, bad headers, inter-byte timeouts and overruns are detected and reported without stalling the receiver.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit time (50 MHz / 115200); must be ≥ 4.
- `TIMEOUT_BITS`, default 20: maximum idle gap between bytes of one frame, in bit times.
- `clock`  input  1  sole clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial line, idle high.
- `cmd_valid`  output  1  command held on `cmd_*`.
- `cmd_ready`  input  1  consumer accepts when `cmd_valid && cmd_ready`.
- `cmd_opcode`  output  3  ALU opcode.
- `cmd_a`  output  8  operand A.
- `cmd_b`  output  8  operand B.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `hdr_err`  output  1  one-cycle pulse: header byte rejected.
- `overrun`  output  1  one-cycle pulse: completed frame dropped.

## Operation
- `rx` passes a 2-FF synchroniser, both stages reset to 1.
- Byte receiver states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: falling edge of synchronised rx → START, bit counter cleared.
  - START: at CLKS_PER_BIT/2 (integer division) re-sample; high → IDLE (glitch, no error), low → DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits LSB first.
  - STOP: sample after CLKS_PER_BIT; high → one-cycle `byte_strobe` with data, → IDLE; low → `frame_err` pulse, byte discarded, wait for rx high before returning to IDLE (held-low break yields exactly one error).
- Frame assembler states: HDR → GET_A → GET_B → HDR.
  - HDR: byte[7:3] must equal 5'b10100 (`CMD_SYNC`); else `hdr_err` pulse, stay HDR. Match → latch byte[2:0] as opcode, → GET_A.
  - GET_A: latch A → GET_B. GET_B: latch B, frame complete → HDR.
  - Timeout counter runs in GET_A/GET_B while byte receiver is IDLE; reaching TIMEOUT_BITS×CLKS_PER_BIT → HDR silently, partial frame dropped.
  - `frame_err` in GET_A/GET_B → HDR (partial frame dropped).
- Output register: on frame complete with `cmd_valid` low, load `cmd_*`, set `cmd_valid`. With `cmd_valid` high and not accepted the same cycle: `overrun` pulse, new frame dropped, held command unchanged. Completion in the same cycle as acceptance loads the new frame (no overrun).
- `cmd_*` stable while `cmd_valid && !cmd_ready`; `cmd_valid` clears the cycle after acceptance.

## Timing
- Reset: all outputs 0, both FSMs at IDLE/HDR, counters 0; a byte or frame in flight is abandoned.
- rx → receiver latency: 2 cycles (synchroniser).
- `byte_strobe` fires mid stop bit: ≈ 9.5 bit times + 2 cycles after the start edge.
- `cmd_valid` rises 1 cycle after the B byte_strobe.
- Error pulses assert exactly one cycle, registered.
- Back-to-back frames with zero idle gap are received without loss provided the consumer accepts within one frame time.

## Structure
- Package `uart_cmd_pkg`: `CMD_SYNC` (5'b10100), receiver state enum, assembler state enum, opcode width (3).
- One sub-module `uart_rx` (synchroniser + byte receiver, outputs `byte_strobe`, `byte_data`, `frame_err`); frame assembler, timeout and output register live in `uart_cmd_rx`.

## Test plan
- CLKS_PER_BIT=8, TIMEOUT_BITS=20 for all cases.
- Send 0xA0, 0x05, 0x0A, `cmd_ready`=1 → one `cmd_valid` cycle with opcode 0, A=5, B=10; no error pulses.
- Send 0x33 then 0xA3, 0x07, 0x02 → one `hdr_err`; then opcode 3, A=7, B=2.
- Send 0xA1, 0x04, then 200-cycle gap, then 0xA2, 0x01, 0x01 → first frame dropped silently; command opcode 2, A=1, B=1.
- Byte 0x55 with stop bit low, then rx held low 100 cycles → exactly one `frame_err`; next valid frame received correctly.
- `cmd_ready`=0, two consecutive frames (0xA4,1,2 then 0xA5,3,4) → command 4/1/2 held stable, one `overrun`; raise ready → accepted, `cmd_valid` drops.
- 3-cycle low glitch on idle rx, and assert `reset` mid-DATA → no byte, no error; after reset a full frame is received normally.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command receiver.
//   CMD_SYNC    : required value of header byte bits [7:3]
//   OPC_W       : ALU opcode width
//   rx_state_e  : byte receiver states
//   asm_state_e : frame assembler states
//   hdr_ok()    : header byte acceptance test
package uart_cmd_pkg;

    localparam logic [4:0] CMD_SYNC = 5'b10100;
    localparam int         OPC_W    = 3;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    typedef enum logic [1:0] {
        ASM_HDR,
        ASM_GET_A,
        ASM_GET_B
    } asm_state_e;

    function automatic logic hdr_ok(input logic [7:0] b);
        return b[7:3] == CMD_SYNC;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver with a 2-FF input synchroniser.
//   clock       : sole clock, rising edge
//   reset       : synchronous, active high
//   rx          : asynchronous serial line, idle high
//   byte_strobe : one-cycle pulse, byte_data valid
//   byte_data   : last received byte
//   frame_err   : one-cycle pulse, stop bit sampled low
//   rx_idle     : receiver waiting for a start edge
//
// state    | meaning
// ---------+-------------------------------------------------------
// RX_IDLE  | line idle, waiting for synchronised rx to go low
// RX_START | half-bit wait, re-sample to reject glitches
// RX_DATA  | sample 8 data bits, one per bit time, LSB first
// RX_STOP  | sample stop bit; high -> strobe, low -> frame_err
// RX_BREAK | stop bit was low; wait for rx high before re-arming
module uart_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_strobe,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       rx_idle
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta_q, rx_sync_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          strobe_q, strobe_d;
    logic [7:0]    data_q, data_d;
    logic          ferr_q, ferr_d;

    // Sampling points are reached when the bit-time down-counter hits zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        strobe_d = 1'b0;
        data_d   = data_q;
        ferr_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                // Only reachable with the line high, so a low level here is a falling edge.
                if (!rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LD;
                    bit_d   = 3'd0;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_sync_q) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_DATA;
                    cnt_d   = FULL_LD;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    sh_d  = {rx_sync_q, sh_q[7:1]};
                    cnt_d = FULL_LD;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_sync_q) begin
                    strobe_d = 1'b1;
                    data_d   = sh_q;
                    state_d  = RX_IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            strobe_q  <= 1'b0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            strobe_q  <= strobe_d;
            data_q    <= data_d;
            ferr_q    <= ferr_d;
        end
    end

    assign byte_strobe = strobe_q;
    assign byte_data   = data_q;
    assign frame_err   = ferr_q;
    assign rx_idle     = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// Serial command receiver: assembles 3-byte frames (header/opcode, A, B)
// from the UART byte stream and presents them on a valid/ready port.
//   clock, reset     : sole clock (rising edge), synchronous active-high reset
//   rx               : asynchronous serial line, idle high
//   cmd_valid/ready  : command handshake
//   cmd_opcode/a/b   : held command fields
//   frame_err        : one-cycle pulse, stop bit low
//   hdr_err          : one-cycle pulse, header byte rejected
//   overrun          : one-cycle pulse, completed frame dropped
//
// state     | meaning
// ----------+------------------------------------------------
// ASM_HDR   | waiting for a header byte matching CMD_SYNC
// ASM_GET_A | header accepted, waiting for operand A
// ASM_GET_B | operand A held, waiting for operand B
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [OPC_W-1:0] cmd_opcode,
    output logic [7:0]       cmd_a,
    output logic [7:0]       cmd_b,
    output logic             frame_err,
    output logic             hdr_err,
    output logic             overrun
);

    localparam int            TOUT_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TW       = $clog2(TOUT_CYC);
    localparam logic [TW-1:0] TOUT_LD  = TW'(TOUT_CYC - 1);

    logic       rx_strobe, rx_ferr, rx_idle;
    logic [7:0] rx_byte;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .byte_strobe(rx_strobe),
        .byte_data  (rx_byte),
        .frame_err  (rx_ferr),
        .rx_idle    (rx_idle)
    );

    asm_state_e       asm_q, asm_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [7:0]       a_q, a_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic             hdr_err_q, hdr_err_d;
    logic             overrun_q, overrun_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [OPC_W-1:0] cmd_opc_q, cmd_opc_d;
    logic [7:0]       cmd_a_q, cmd_a_d;
    logic [7:0]       cmd_b_q, cmd_b_d;
    logic             frame_done;
    logic             accept;

    always_comb begin
        asm_d       = asm_q;
        opc_d       = opc_q;
        a_d         = a_q;
        to_cnt_d    = TOUT_LD;
        hdr_err_d   = 1'b0;
        frame_done  = 1'b0;
        overrun_d   = 1'b0;
        cmd_opc_d   = cmd_opc_q;
        cmd_a_d     = cmd_a_q;
        cmd_b_d     = cmd_b_q;
        accept      = cmd_valid_q && cmd_ready;
        cmd_valid_d = cmd_valid_q && !accept;

        if (rx_ferr) begin
            asm_d = ASM_HDR;
        end else if (rx_strobe) begin
            case (asm_q)
                ASM_HDR: begin
                    if (hdr_ok(rx_byte)) begin
                        opc_d = rx_byte[OPC_W-1:0];
                        asm_d = ASM_GET_A;
                    end else begin
                        hdr_err_d = 1'b1;
                    end
                end
                ASM_GET_A: begin
                    a_d   = rx_byte;
                    asm_d = ASM_GET_B;
                end
                ASM_GET_B: begin
                    frame_done = 1'b1;
                    asm_d      = ASM_HDR;
                end
                default: asm_d = ASM_HDR;
            endcase
        end else if (asm_q != ASM_HDR && rx_idle) begin
            // Inter-byte gap timer; reloads whenever a byte is in flight.
            if (to_cnt_q == '0) begin
                asm_d = ASM_HDR;
            end else begin
                to_cnt_d = to_cnt_q - 1'b1;
            end
        end

        // A slot freed by acceptance this cycle can take the new frame.
        if (frame_done) begin
            if (!cmd_valid_q || accept) begin
                cmd_valid_d = 1'b1;
                cmd_opc_d   = opc_q;
                cmd_a_d     = a_q;
                cmd_b_d     = rx_byte;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            asm_q       <= ASM_HDR;
            opc_q       <= '0;
            a_q         <= '0;
            to_cnt_q    <= TOUT_LD;
            hdr_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_opc_q   <= '0;
            cmd_a_q     <= '0;
            cmd_b_q     <= '0;
        end else begin
            asm_q       <= asm_d;
            opc_q       <= opc_d;
            a_q         <= a_d;
            to_cnt_q    <= to_cnt_d;
            hdr_err_q   <= hdr_err_d;
            overrun_q   <= overrun_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_opc_q   <= cmd_opc_d;
            cmd_a_q     <= cmd_a_d;
            cmd_b_q     <= cmd_b_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_opcode = cmd_opc_q;
    assign cmd_a      = cmd_a_q;
    assign cmd_b      = cmd_b_q;
    assign frame_err  = rx_ferr;
    assign hdr_err    = hdr_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with CLKS_PER_BIT=8, TIMEOUT_BITS=20.
module tb_uart_cmd_rx;

    localparam int CPB = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [2:0] cmd_opcode;
    logic [7:0] cmd_a, cmd_b;
    logic       frame_err, hdr_err, overrun;

    always #5 clock = ~clock;

    uart_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(20)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .frame_err (frame_err),
        .hdr_err   (hdr_err),
        .overrun   (overrun)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Event counters maintained by the monitor.
    int         n_acc = 0, n_ferr = 0, n_herr = 0, n_ovr = 0, n_unstable = 0;
    logic [2:0] last_op = '0;
    logic [7:0] last_a = '0, last_b = '0;
    logic       held = 1'b0;
    logic [18:0] held_v = '0;

    always @(negedge clock) begin
        if (cmd_valid && cmd_ready) begin
            n_acc   <= n_acc + 1;
            last_op <= cmd_opcode;
            last_a  <= cmd_a;
            last_b  <= cmd_b;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (hdr_err)   n_herr <= n_herr + 1;
        if (overrun)   n_ovr  <= n_ovr + 1;
        if (cmd_valid && !cmd_ready) begin
            if (held && held_v != {cmd_opcode, cmd_a, cmd_b}) n_unstable <= n_unstable + 1;
            held   <= 1'b1;
            held_v <= {cmd_opcode, cmd_a, cmd_b};
        end else begin
            held <= 1'b0;
        end
    end

    int b_acc, b_ferr, b_herr, b_ovr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic snap();
        b_acc  = n_acc;
        b_ferr = n_ferr;
        b_herr = n_herr;
        b_ovr  = n_ovr;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b);
        send_byte(h, 1'b1);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
    endtask

    task automatic check_cmd(input string tag, input int acc, input logic [2:0] op,
                             input logic [7:0] a, input logic [7:0] b);
        check_eq({tag, "_acc"}, n_acc - b_acc, acc);
        check_eq({tag, "_op"}, last_op, op);
        check_eq({tag, "_a"}, last_a, a);
        check_eq({tag, "_b"}, last_b, b);
    endtask

    task automatic check_errs(input string tag, input int ef, input int eh, input int eo);
        check_eq({tag, "_ferr"}, n_ferr - b_ferr, ef);
        check_eq({tag, "_herr"}, n_herr - b_herr, eh);
        check_eq({tag, "_ovr"}, n_ovr - b_ovr, eo);
    endtask

    initial begin
        idle(4);
        check_eq("rst_valid", cmd_valid, 0);
        check_eq("rst_op", cmd_opcode, 0);
        check_eq("rst_a", cmd_a, 0);
        check_eq("rst_b", cmd_b, 0);
        check_eq("rst_errs", {frame_err, hdr_err, overrun}, 0);
        reset = 1'b0;
        idle(4);

        // Basic frame.
        snap();
        send_frame(8'hA0, 8'h05, 8'h0A);
        idle(20);
        check_cmd("t1", 1, 3'd0, 8'h05, 8'h0A);
        check_errs("t1", 0, 0, 0);
        check_eq("t1_valid", cmd_valid, 0);

        // Bad header then good frame.
        snap();
        send_byte(8'h33, 1'b1);
        send_frame(8'hA3, 8'h07, 8'h02);
        idle(20);
        check_cmd("t2", 1, 3'd3, 8'h07, 8'h02);
        check_errs("t2", 0, 1, 0);

        // Inter-byte timeout drops the partial frame.
        snap();
        send_byte(8'hA1, 1'b1);
        send_byte(8'h04, 1'b1);
        idle(200);
        send_frame(8'hA2, 8'h01, 8'h01);
        idle(20);
        check_cmd("t3", 1, 3'd2, 8'h01, 8'h01);
        check_errs("t3", 0, 0, 0);

        // Framing error followed by a held-low break.
        snap();
        send_byte(8'h55, 1'b0);
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(20);
        check_errs("t4brk", 1, 0, 0);
        check_eq("t4brk_acc", n_acc - b_acc, 0);
        snap();
        send_frame(8'hA6, 8'h3C, 8'hC3);
        idle(20);
        check_cmd("t4", 1, 3'd6, 8'h3C, 8'hC3);
        check_errs("t4", 0, 0, 0);

        // Back-pressure: second frame overruns, first held stable.
        snap();
        cmd_ready = 1'b0;
        send_frame(8'hA4, 8'h01, 8'h02);
        send_frame(8'hA5, 8'h03, 8'h04);
        idle(20);
        check_eq("t5_valid", cmd_valid, 1);
        check_eq("t5_op", cmd_opcode, 4);
        check_eq("t5_a", cmd_a, 8'h01);
        check_eq("t5_b", cmd_b, 8'h02);
        check_eq("t5_stable", n_unstable, 0);
        check_errs("t5", 0, 0, 1);
        check_eq("t5_noacc", n_acc - b_acc, 0);
        @(posedge clock);
        #1 cmd_ready = 1'b1;
        idle(3);
        check_eq("t5_drop", cmd_valid, 0);
        check_cmd("t5", 1, 3'd4, 8'h01, 8'h02);

        // Glitch, then reset mid-DATA with the assembler mid-frame.
        snap();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        send_byte(8'hA1, 1'b1);
        rx = 1'b0;
        idle(CPB * 4);
        reset = 1'b1;
        rx = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(30);
        check_errs("t6rst", 0, 0, 0);
        check_eq("t6rst_acc", n_acc - b_acc, 0);
        check_eq("t6rst_valid", cmd_valid, 0);
        snap();
        send_frame(8'hA7, 8'h11, 8'h22);
        idle(20);
        check_cmd("t6", 1, 3'd7, 8'h11, 8'h22);
        check_errs("t6", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
